// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and sequencer for a single-port memory
// with a registered (one-cycle latency) read port.
//
// Ports:
//   i_clk, i_reset_n        clock (rising edge), asynchronous active-low reset
//   i_req_x, i_r_w_x        request and direction (1 = write) for port x in {a, b}
//   i_addr_x, i_din_x       request address and write data for port x
//   o_ack_x                 one-cycle completion pulse to port x
//   o_dout_x                read data for port x, held until the next read on that port
//   o_busy                  high whenever a transaction is in flight
//   o_mem_valid/r_w/addr/din  memory command, driven from registers
//   i_mem_dout              memory read data, valid the cycle after the read command
module mem_arbiter #(
    parameter int unsigned AddrSize = 8,
    parameter int unsigned DataSize = 32
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_req_a,
    input  logic                i_r_w_a,
    input  logic [AddrSize-1:0] i_addr_a,
    input  logic [DataSize-1:0] i_din_a,
    input  logic                i_req_b,
    input  logic                i_r_w_b,
    input  logic [AddrSize-1:0] i_addr_b,
    input  logic [DataSize-1:0] i_din_b,
    output logic                o_ack_a,
    output logic [DataSize-1:0] o_dout_a,
    output logic                o_ack_b,
    output logic [DataSize-1:0] o_dout_b,
    output logic                o_busy,
    output logic                o_mem_valid,
    output logic                o_mem_r_w,
    output logic [AddrSize-1:0] o_mem_addr,
    output logic [DataSize-1:0] o_mem_din,
    input  logic [DataSize-1:0] i_mem_dout
);

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StAck} state_t;

    state_t                r_state;
    logic                  r_last_gnt_b;  // 1: port B won the most recent grant
    logic                  r_gnt_b;       // owner of the transaction in flight
    logic                  r_ack_a;
    logic                  r_ack_b;
    logic [DataSize-1:0]   r_dout_a;
    logic [DataSize-1:0]   r_dout_b;
    logic                  r_busy;
    logic                  r_mem_valid;
    logic                  r_mem_r_w;
    logic [AddrSize-1:0]   r_mem_addr;
    logic [DataSize-1:0]   r_mem_din;

    logic                  w_any_req;
    logic                  w_pick_b;

    assign w_any_req = i_req_a | i_req_b;
    // B wins when it is alone, or on a tie when A held the previous grant.
    assign w_pick_b  = i_req_b & (~i_req_a | ~r_last_gnt_b);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_last_gnt_b <= 1'b1;  // so A wins the first tie
            r_gnt_b      <= 1'b0;
            r_ack_a      <= 1'b0;
            r_ack_b      <= 1'b0;
            r_dout_a     <= '0;
            r_dout_b     <= '0;
            r_busy       <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_r_w    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
        end else begin
            // Single-cycle pulses default low.
            r_mem_valid <= 1'b0;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_gnt_b      <= w_pick_b;
                        r_last_gnt_b <= w_pick_b;
                        r_mem_r_w    <= w_pick_b ? i_r_w_b  : i_r_w_a;
                        r_mem_addr   <= w_pick_b ? i_addr_b : i_addr_a;
                        r_mem_din    <= w_pick_b ? i_din_b  : i_din_a;
                        r_mem_valid  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= StIssue;
                    end
                end
                StIssue: begin
                    if (r_mem_r_w) begin
                        r_ack_a <= ~r_gnt_b;
                        r_ack_b <= r_gnt_b;
                        r_state <= StAck;
                    end else begin
                        r_state <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (r_gnt_b) begin
                        r_dout_b <= i_mem_dout;
                    end else begin
                        r_dout_a <= i_mem_dout;
                    end
                    r_ack_a <= ~r_gnt_b;
                    r_ack_b <= r_gnt_b;
                    r_state <= StAck;
                end
                StAck: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_ack_a     = r_ack_a;
    assign o_ack_b     = r_ack_b;
    assign o_dout_a    = r_dout_a;
    assign o_dout_b    = r_dout_b;
    assign o_busy      = r_busy;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_r_w   = r_mem_r_w;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural registered-read
// memory, a transaction-timeline reference model, and directed scenarios.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a = 1'b0, r_w_a = 1'b0, req_b = 1'b0, r_w_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;
    logic          ack_a, ack_b, busy, mem_valid, mem_r_w;
    logic [DW-1:0] dout_a, dout_b, mem_din;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.AddrSize(AW), .DataSize(DW)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_a(req_a), .i_r_w_a(r_w_a), .i_addr_a(addr_a), .i_din_a(din_a),
        .i_req_b(req_b), .i_r_w_b(r_w_b), .i_addr_b(addr_b), .i_din_b(din_b),
        .o_ack_a(ack_a), .o_dout_a(dout_a), .o_ack_b(ack_b), .o_dout_b(dout_b),
        .o_busy(busy), .o_mem_valid(mem_valid), .o_mem_r_w(mem_r_w),
        .o_mem_addr(mem_addr), .o_mem_din(mem_din), .i_mem_dout(mem_dout)
    );

    // Memory stand-in: write on the Valid edge, registered read data.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_valid) begin
            if (mem_r_w) mem[mem_addr] <= mem_din;
            else         mem_dout <= mem[mem_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a granted transaction follows a fixed timeline counted in edges
    // since its grant edge. Write: ack after edge 1, free after edge 2.
    // Read: data + ack after edge 2, free after edge 3.
    logic [DW-1:0] sh_mem [0:255];
    bit            m_active, m_port, m_rw, m_last;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic          e_valid, e_ack_a, e_ack_b, e_busy, e_rw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_dout_a, e_dout_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_last = 1; m_age = 0;
            e_valid = 0; e_ack_a = 0; e_ack_b = 0; e_busy = 0; e_rw = 0;
            e_addr = '0; e_din = '0; e_dout_a = '0; e_dout_b = '0;
        end else begin
            e_valid = 0; e_ack_a = 0; e_ack_b = 0;
            if (m_active) begin
                m_age++;
                if (m_rw && m_age == 1) begin
                    sh_mem[m_addr] = m_din;
                    if (m_port) e_ack_b = 1; else e_ack_a = 1;
                end
                if (!m_rw && m_age == 2) begin
                    if (m_port) begin e_dout_b = sh_mem[m_addr]; e_ack_b = 1; end
                    else        begin e_dout_a = sh_mem[m_addr]; e_ack_a = 1; end
                end
                if (m_age == (m_rw ? 2 : 3)) m_active = 0;
            end else if (req_a || req_b) begin
                if (req_a && req_b) m_port = !m_last;
                else                m_port = req_b;
                m_rw   = m_port ? r_w_b  : r_w_a;
                m_addr = m_port ? addr_b : addr_a;
                m_din  = m_port ? din_b  : din_a;
                m_last = m_port; m_active = 1; m_age = 0;
                e_valid = 1; e_rw = m_rw; e_addr = m_addr; e_din = m_din;
            end
            e_busy = m_active;
        end
    end

    // Per-cycle comparison against the model, plus Ack exclusivity/width.
    bit   chk_en = 0;
    logic prev_ack_a = 0, prev_ack_b = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack_a = 0; prev_ack_b = 0;
        end else if (chk_en) begin
            check("mem_valid", mem_valid, e_valid);
            check("ack_a", ack_a, e_ack_a);
            check("ack_b", ack_b, e_ack_b);
            check("busy", busy, e_busy);
            check("dout_a", dout_a, e_dout_a);
            check("dout_b", dout_b, e_dout_b);
            if (e_busy) begin
                check("mem_r_w", mem_r_w, e_rw);
                check("mem_addr", mem_addr, e_addr);
                check("mem_din", mem_din, e_din);
            end
            check("ack_overlap", ack_a & ack_b, 1'b0);
            check("ack_a_width", prev_ack_a & ack_a, 1'b0);
            check("ack_b_width", prev_ack_b & ack_b, 1'b0);
            prev_ack_a = ack_a; prev_ack_b = ack_b;
        end
    end

    // One transaction on one port; returns cycles from request to Ack (0 when no Ack
    // arrives), the command in cycle 1, and Dout while Ack is high.
    task automatic run_txn(input bit port, input bit rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit perturb, output int lat,
                           output logic v1, output logic rw1, output logic [AW-1:0] a1,
                           output logic [DW-1:0] dack);
        lat = 0; v1 = 0; rw1 = 0; a1 = '0; dack = '0;
        @(negedge clk);
        if (port) begin req_b = 1; r_w_b = rw; addr_b = a; din_b = d; end
        else      begin req_a = 1; r_w_a = rw; addr_a = a; din_a = d; end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                v1 = mem_valid; rw1 = mem_r_w; a1 = mem_addr;
                if (perturb) begin
                    if (port) begin addr_b = a + 8'd1; din_b = 32'h1234; end
                    else      begin addr_a = a + 8'd1; din_a = 32'h1234; end
                end
            end
            if ((port ? ack_b : ack_a) === 1'b1) begin
                lat = n; dack = port ? dout_b : dout_a;
                break;
            end
        end
        @(posedge clk); #1;
        if (port) req_b = 0; else req_a = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            lat;
        logic          v1, rw1;
        logic [AW-1:0] a1;
        logic [DW-1:0] dack;
        int            cnt;
        bit            order [0:3];
        bit            exp_order [0:3];

        for (int i = 0; i < 256; i++) begin mem[i] = '0; sh_mem[i] = '0; end
        mem[1] = 32'h11; sh_mem[1] = 32'h11;
        mem[2] = 32'h22; sh_mem[2] = 32'h22;
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        chk_en = 1;

        // Single write then read on A.
        run_txn(0, 1, 8'h10, 32'hDEADBEEF, 0, lat, v1, rw1, a1, dack);
        check("wr_valid_c1", v1, 1'b1);
        check("wr_rw_c1", rw1, 1'b1);
        check("wr_addr_c1", a1, 8'h10);
        check("wr_lat", lat, 2);
        run_txn(0, 0, 8'h10, 32'h0, 0, lat, v1, rw1, a1, dack);
        check("rd_lat", lat, 3);
        check("rd_data", dack, 32'hDEADBEEF);

        // Reset while an A read sits in RDWAIT.
        @(negedge clk);
        req_a = 1; r_w_a = 0; addr_a = 8'h02;
        @(negedge clk);
        @(negedge clk);
        check("rdwait_busy", busy, 1'b1);
        #1 rst_n = 0; req_a = 0;
        #1;
        check("rst_outputs", {ack_a, ack_b, busy, mem_valid, mem_r_w}, 5'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_din", mem_din, 32'h0);
        check("rst_dout_a", dout_a, 32'h0);
        check("rst_dout_b", dout_b, 32'h0);
        @(negedge clk);
        check("rst_no_ack", ack_a | ack_b, 1'b0);
        #2 rst_n = 1;

        // Contention: both ports read, held through four transactions.
        @(negedge clk);
        req_a = 1; r_w_a = 0; addr_a = 8'h01;
        req_b = 1; r_w_b = 0; addr_b = 8'h02;
        cnt = 0;
        for (int n = 0; n < 60 && cnt < 4; n++) begin
            @(negedge clk);
            if (ack_a === 1'b1) begin
                order[cnt] = 0; cnt++;
                check("cont_dout_a", dout_a, 32'h11);
            end
            if (ack_b === 1'b1) begin
                order[cnt] = 1; cnt++;
                check("cont_dout_b", dout_b, 32'h22);
                check("cont_dout_a_held", dout_a, 32'h11);
            end
            if (cnt == 4) begin
                @(posedge clk); #1;
                req_a = 0; req_b = 0;
            end
        end
        check("cont_count", cnt, 4);
        for (int i = 0; i < 4; i++) check("cont_order", order[i], exp_order[i]);

        // Latch at grant: fields change after grant, memory sees the originals.
        run_txn(0, 1, 8'h30, 32'h55550000, 1, lat, v1, rw1, a1, dack);
        check("latch_lat", lat, 2);
        check("latch_mem_orig", mem[8'h30], 32'h55550000);
        check("latch_mem_other", mem[8'h31], 32'h0);

        // Write on A to top address, read back on B.
        run_txn(0, 1, 8'hFF, 32'hA5A5A5A5, 0, lat, v1, rw1, a1, dack);
        check("xwr_lat", lat, 2);
        run_txn(1, 0, 8'hFF, 32'h0, 0, lat, v1, rw1, a1, dack);
        check("xrd_lat", lat, 3);
        check("xrd_data", dack, 32'hA5A5A5A5);
        check("xrd_dout_a_kept", dout_a, 32'h11);

        // Idle: nothing requested for ten cycles.
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("idle_quiet", {mem_valid, busy, ack_a, ack_b}, 4'b0);
            check("idle_addr", mem_addr, 8'hFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
